uop_commit_merger: RTL and testbench

Commit-side counterpart of the micro-op sequencer: each tensor macro-instruction is issued as a fixed-length burst of micro-ops, and every one of them completes individually. This block absorbs those per-uop completions, tracks one open group per warp, and emits a single merged commit when a warp's group closes. It sits between the tensor unit's writeback/commit output and the core commit stage. Non-uop commits pass through unchanged.

---
 rtl/VX_gpu_pkg.sv | 25 ++
 rtl/uop_group_tracker.sv | 80 ++++++++
 rtl/uop_commit_merger.sv | 129 ++++++++++++
 tb/tb_uop_commit_merger.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions used by the micro-op sequencer and the commit merger.
package VX_gpu_pkg;

    // Micro-ops issued per tensor macro-instruction (HMMA).
    localparam int UOP_HMMA_COUNT = 32;

    // Default core geometry for the commit path.
    localparam int UC_NUM_WARPS   = 8;
    localparam int UC_NUM_THREADS = 4;
    localparam int UC_UUID_W      = 44;
    localparam int UC_NR_BITS     = 6;
    localparam int UC_WID_W       = $clog2(UC_NUM_WARPS);

    // One uop completion as seen on the commit side.
    typedef struct packed {
        logic                      is_uop;
        logic                      last;
        logic [UC_WID_W-1:0]       wid;
        logic [UC_UUID_W-1:0]      uuid;
        logic [UC_NUM_THREADS-1:0] tmask;
        logic                      wb;
        logic [UC_NR_BITS-1:0]     rd;
    } uop_commit_t;

endpackage

// File: rtl/uop_group_tracker.sv
// Tracks one warp's open uop group and flags protocol violations on the
// completion currently presented for this warp.
module uop_group_tracker
    import VX_gpu_pkg::*;
#(
    parameter int NUM_THREADS = UC_NUM_THREADS,
    parameter int UOP_COUNT   = UOP_HMMA_COUNT,
    parameter int UUID_W      = UC_UUID_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_sel,
    input  logic                   i_last,
    input  logic [UUID_W-1:0]      i_uuid,
    input  logic [NUM_THREADS-1:0] i_tmask,
    input  logic                   i_wb,
    output logic                   o_open,
    output logic [UUID_W-1:0]      o_uuid,
    output logic [NUM_THREADS-1:0] o_tmask,
    output logic                   o_wb,
    output logic                   o_err
);

    localparam int CNT_W = $clog2(UOP_COUNT);

    logic                   r_open;
    logic [CNT_W-1:0]       r_cnt;
    logic [UUID_W-1:0]      r_uuid;
    logic [NUM_THREADS-1:0] r_tmask;
    logic                   r_wb_or;

    logic [CNT_W-1:0]       w_cnt_eff;
    logic [CNT_W:0]         w_cnt_inc;
    logic                   w_mismatch;
    logic                   w_short;
    logic                   w_ovf;

    // A closed warp counts as zero uops seen; the extra bit keeps the
    // "count including the last uop" compare from wrapping.
    assign w_cnt_eff  = r_open ? r_cnt : '0;
    assign w_cnt_inc  = {1'b0, w_cnt_eff} + (CNT_W+1)'(1);
    assign w_mismatch = r_open & ((i_uuid != r_uuid) | (i_tmask != r_tmask));
    assign w_short    = i_last & (w_cnt_inc != (CNT_W+1)'(UOP_COUNT));
    assign w_ovf      = ~i_last & r_open & (r_cnt == CNT_W'(UOP_COUNT - 1));

    assign o_err   = w_mismatch | w_short | w_ovf;
    assign o_open  = r_open;
    // Merged fields for a closing uop: captured values if the group was
    // open, otherwise the last uop stands alone.
    assign o_uuid  = r_open ? r_uuid  : i_uuid;
    assign o_tmask = r_open ? r_tmask : i_tmask;
    assign o_wb    = (r_open & r_wb_or) | i_wb;

    // Group state: open on first uop, count/accumulate, close on last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_open  <= 1'b0;
            r_cnt   <= '0;
            r_uuid  <= '0;
            r_tmask <= '0;
            r_wb_or <= 1'b0;
        end else if (i_sel) begin
            if (i_last) begin
                r_open <= 1'b0;
                r_cnt  <= '0;
            end else if (!r_open) begin
                r_open  <= 1'b1;
                r_cnt   <= CNT_W'(1);
                r_uuid  <= i_uuid;
                r_tmask <= i_tmask;
                r_wb_or <= i_wb;
            end else begin
                // Overflowing group wraps the count but stays open.
                r_cnt   <= w_ovf ? '0 : r_cnt + CNT_W'(1);
                r_wb_or <= r_wb_or | i_wb;
            end
        end
    end

endmodule

// File: rtl/uop_commit_merger.sv
// Merges per-uop completions of microcoded macro-instructions into one commit
// per warp group; non-uop commits pass straight through the output register.
module uop_commit_merger
    import VX_gpu_pkg::*;
#(
    parameter int NUM_WARPS   = UC_NUM_WARPS,
    parameter int NUM_THREADS = UC_NUM_THREADS,
    parameter int UOP_COUNT   = UOP_HMMA_COUNT,
    parameter int UUID_W      = UC_UUID_W,
    parameter int NR_BITS     = UC_NR_BITS,
    parameter int WID_W       = $clog2(NUM_WARPS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_is_uop,
    input  logic                   in_last,
    input  logic [WID_W-1:0]       in_wid,
    input  logic [UUID_W-1:0]      in_uuid,
    input  logic [NUM_THREADS-1:0] in_tmask,
    input  logic                   in_wb,
    input  logic [NR_BITS-1:0]     in_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WID_W-1:0]       out_wid,
    output logic [UUID_W-1:0]      out_uuid,
    output logic [NUM_THREADS-1:0] out_tmask,
    output logic                   out_wb,
    output logic [NR_BITS-1:0]     out_rd,
    output logic [NUM_WARPS-1:0]   open_mask,
    output logic                   err,
    output logic [WID_W-1:0]       err_wid
);

    logic                                  w_accept;
    logic                                  w_load;
    logic                                  w_hit_err;
    logic [NUM_WARPS-1:0]                  w_sel;
    logic [NUM_WARPS-1:0]                  w_open;
    logic [NUM_WARPS-1:0]                  w_trk_err;
    logic [NUM_WARPS-1:0]                  w_grp_wb;
    logic [NUM_WARPS-1:0][UUID_W-1:0]      w_grp_uuid;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0] w_grp_tmask;

    logic                   r_out_valid;
    logic [WID_W-1:0]       r_out_wid;
    logic [UUID_W-1:0]      r_out_uuid;
    logic [NUM_THREADS-1:0] r_out_tmask;
    logic                   r_out_wb;
    logic [NR_BITS-1:0]     r_out_rd;
    logic                   r_err;
    logic [WID_W-1:0]       r_err_wid;

    // Single output register: accept whenever it is empty or draining.
    assign in_ready  = ~r_out_valid | out_ready;
    assign w_accept  = in_valid & in_ready;
    assign w_load    = w_accept & (~in_is_uop | in_last);
    assign w_hit_err = w_accept & in_is_uop & w_trk_err[in_wid];

    genvar g;
    generate
        for (g = 0; g < NUM_WARPS; g++) begin : g_warp
            assign w_sel[g] = w_accept & in_is_uop & (in_wid == WID_W'(g));

            uop_group_tracker #(
                .NUM_THREADS (NUM_THREADS),
                .UOP_COUNT   (UOP_COUNT),
                .UUID_W      (UUID_W)
            ) u_trk (
                .clk     (clk),
                .reset_n (reset_n),
                .i_sel   (w_sel[g]),
                .i_last  (in_last),
                .i_uuid  (in_uuid),
                .i_tmask (in_tmask),
                .i_wb    (in_wb),
                .o_open  (w_open[g]),
                .o_uuid  (w_grp_uuid[g]),
                .o_tmask (w_grp_tmask[g]),
                .o_wb    (w_grp_wb[g]),
                .o_err   (w_trk_err[g])
            );
        end
    endgenerate

    // Output register: load a passthrough or merged commit, else drain on ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_wid   <= '0;
            r_out_uuid  <= '0;
            r_out_tmask <= '0;
            r_out_wb    <= 1'b0;
            r_out_rd    <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_wid   <= in_wid;
            r_out_uuid  <= in_is_uop ? w_grp_uuid[in_wid]  : in_uuid;
            r_out_tmask <= in_is_uop ? w_grp_tmask[in_wid] : in_tmask;
            r_out_wb    <= in_is_uop ? w_grp_wb[in_wid]    : in_wb;
            r_out_rd    <= in_rd;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Violation pulse; the warp id is held until the next violation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err     <= 1'b0;
            r_err_wid <= '0;
        end else begin
            r_err <= w_hit_err;
            if (w_hit_err) r_err_wid <= in_wid;
        end
    end

    assign out_valid = r_out_valid;
    assign out_wid   = r_out_wid;
    assign out_uuid  = r_out_uuid;
    assign out_tmask = r_out_tmask;
    assign out_wb    = r_out_wb;
    assign out_rd    = r_out_rd;
    assign open_mask = w_open;
    assign err       = r_err;
    assign err_wid   = r_err_wid;

endmodule

// File: tb/tb_uop_commit_merger.sv
// Directed scenarios plus randomized traffic checked against a group-level model.
module tb_uop_commit_merger;

    localparam int NW = 8;
    localparam int NT = 4;
    localparam int UC = 32;
    localparam int UW = 44;
    localparam int NR = 6;
    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_is_uop = 1'b0;
    logic          in_last = 1'b0;
    logic [WW-1:0] in_wid = '0;
    logic [UW-1:0] in_uuid = '0;
    logic [NT-1:0] in_tmask = '0;
    logic          in_wb = 1'b0;
    logic [NR-1:0] in_rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WW-1:0] out_wid;
    logic [UW-1:0] out_uuid;
    logic [NT-1:0] out_tmask;
    logic          out_wb;
    logic [NR-1:0] out_rd;
    logic [NW-1:0] open_mask;
    logic          err;
    logic [WW-1:0] err_wid;

    always #5 clk = ~clk;

    uop_commit_merger #(
        .NUM_WARPS(NW), .NUM_THREADS(NT), .UOP_COUNT(UC), .UUID_W(UW), .NR_BITS(NR)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_uop(in_is_uop),
        .in_last(in_last), .in_wid(in_wid), .in_uuid(in_uuid), .in_tmask(in_tmask),
        .in_wb(in_wb), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid),
        .out_uuid(out_uuid), .out_tmask(out_tmask), .out_wb(out_wb), .out_rd(out_rd),
        .open_mask(open_mask), .err(err), .err_wid(err_wid)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int n_hs = 0;
    int n_errs = 0;
    bit last_acc = 1'b0;

    // Reference model: group bookkeeping per warp and the pending commit.
    bit            m_valid;
    logic [WW-1:0] m_wid;
    logic [UW-1:0] m_uuid;
    logic [NT-1:0] m_tmask;
    bit            m_wb;
    logic [NR-1:0] m_rd;
    bit            m_err;
    logic [WW-1:0] m_err_wid;
    bit            m_open [NW];
    int            m_cnt [NW];
    logic [UW-1:0] m_guuid [NW];
    logic [NT-1:0] m_gtmask [NW];
    bit            m_gwb [NW];

    // Random generator state per warp.
    int            g_pos [NW];
    logic [UW-1:0] g_uuid [NW];
    logic [NT-1:0] g_tm [NW];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] m_mask();
        logic [NW-1:0] r;
        for (int w = 0; w < NW; w++) r[w] = m_open[w];
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wid = '0; m_uuid = '0; m_tmask = '0; m_wb = 0; m_rd = '0;
        m_err = 0; m_err_wid = '0;
        for (int w = 0; w < NW; w++) begin
            m_open[w] = 0; m_cnt[w] = 0; m_guuid[w] = '0; m_gtmask[w] = '0; m_gwb[w] = 0;
        end
    endtask

    task automatic model_step(input bit acc);
        bit e, ld;
        int w;
        e = 0; ld = 0;
        w = int'(in_wid);
        if (acc) begin
            if (!in_is_uop) begin
                ld = 1;
                m_wid = in_wid; m_uuid = in_uuid; m_tmask = in_tmask; m_wb = in_wb; m_rd = in_rd;
            end else begin
                if (m_open[w] && (in_uuid != m_guuid[w] || in_tmask != m_gtmask[w])) e = 1;
                if (in_last) begin
                    if ((m_open[w] ? m_cnt[w] : 0) + 1 != UC) e = 1;
                    ld = 1;
                    m_wid   = in_wid;
                    m_uuid  = m_open[w] ? m_guuid[w] : in_uuid;
                    m_tmask = m_open[w] ? m_gtmask[w] : in_tmask;
                    m_wb    = (m_open[w] && m_gwb[w]) || in_wb;
                    m_rd    = in_rd;
                    m_open[w] = 0; m_cnt[w] = 0;
                end else if (!m_open[w]) begin
                    m_open[w] = 1; m_cnt[w] = 1;
                    m_guuid[w] = in_uuid; m_gtmask[w] = in_tmask; m_gwb[w] = in_wb;
                end else begin
                    if (m_cnt[w] == UC - 1) begin
                        e = 1; m_cnt[w] = 0;
                    end else begin
                        m_cnt[w]++;
                    end
                    m_gwb[w] = m_gwb[w] || in_wb;
                end
            end
            if (e) m_err_wid = in_wid;
        end
        if (ld) m_valid = 1;
        else if (out_ready) m_valid = 0;
        m_err = e;
    endtask

    task automatic compare_all(input bit full);
        chk("out_valid", out_valid, m_valid);
        if (m_valid || full) begin
            chk("out_wid", out_wid, m_wid);
            chk("out_uuid", out_uuid, m_uuid);
            chk("out_tmask", out_tmask, m_tmask);
            chk("out_wb", out_wb, m_wb);
            chk("out_rd", out_rd, m_rd);
        end
        chk("open_mask", open_mask, m_mask());
        chk("err", err, m_err);
        if (m_err || full) chk("err_wid", err_wid, m_err_wid);
    endtask

    // One clock: handshake decided at negedge, model advanced at posedge.
    task automatic cyc();
        bit exp_rdy;
        @(negedge clk);
        exp_rdy = !m_valid || out_ready;
        chk("in_ready", in_ready, exp_rdy);
        if (out_valid && out_ready) n_hs++;
        last_acc = in_valid && exp_rdy;
        @(posedge clk);
        model_step(last_acc);
        #1;
        compare_all(0);
        if (err) n_errs++;
    endtask

    task automatic put(input bit uop, input int w, input logic [UW-1:0] u, input logic [NT-1:0] tm,
                       input bit last, input bit wb, input logic [NR-1:0] rd);
        in_valid = 1; in_is_uop = uop; in_wid = WW'(w); in_uuid = u; in_tmask = tm;
        in_last = last; in_wb = wb; in_rd = rd;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (last_acc) break;
        end
        if (!last_acc) chk("accept_timeout", last_acc, 1);
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        in_valid = 0;
        reset_n = 0;
        #1;
        model_reset();
        compare_all(1);
        chk("rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h0, e0, w;
        model_reset();
        #2;
        do_reset();

        // Single group on warp 2.
        h0 = n_hs;
        for (int i = 1; i <= UC; i++) begin
            put(1, 2, 44'h55, 4'b1111, i == UC, i == 7, 6'd9);
            if (i == 1) chk("single_open_after1", open_mask[2], 1);
        end
        chk("single_open_closed", open_mask[2], 0);
        chk("single_valid", out_valid, 1);
        chk("single_wid", out_wid, 2);
        chk("single_uuid", out_uuid, 44'h55);
        chk("single_wb", out_wb, 1);
        idle(2);
        chk("single_commits", n_hs - h0, 1);

        // Interleaved warps 0 and 3.
        h0 = n_hs; e0 = n_errs;
        for (int i = 0; i < 2 * UC; i++) begin
            w = (i % 2 == 1) ? 3 : 0;
            put(1, w, 44'h100 + 44'(w), 4'b1010, (i / 2 + 1) == UC, 0, 6'(w));
        end
        idle(2);
        chk("ilv_commits", n_hs - h0, 2);
        chk("ilv_errs", n_errs - e0, 0);

        // Passthrough under backpressure.
        out_ready = 0;
        put(0, 6, 44'h123, 4'h3, 0, 1, 6'd5);
        in_valid = 1; in_is_uop = 0; in_wid = 3'd1; in_rd = 6'd6;
        repeat (4) cyc();
        chk("bp_valid", out_valid, 1);
        chk("bp_rd", out_rd, 5);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1;
        cyc();
        chk("bp_next_rd", out_rd, 6);
        idle(2);

        // Short group on warp 1.
        for (int i = 1; i <= 10; i++) put(1, 1, 44'h31, 4'b0111, i == 10, 0, 6'd2);
        chk("short_err", err, 1);
        chk("short_err_wid", err_wid, 1);
        chk("short_commit", out_valid, 1);
        idle(2);

        // Uuid mismatch on warp 4, group continues.
        for (int i = 1; i <= UC; i++) begin
            put(1, 4, (i == 3) ? 44'h77 : 44'h76, 4'b1100, i == UC, 0, 6'd3);
            if (i == 3) begin
                chk("uuid_err", err, 1);
                chk("uuid_err_wid", err_wid, 4);
            end
        end
        chk("uuid_commit_uuid", out_uuid, 44'h76);
        idle(2);

        // Reset in the middle of a warp-5 group.
        for (int i = 1; i <= 16; i++) put(1, 5, 44'h5A, 4'b1111, 0, 0, 6'd1);
        chk("mid_open5", open_mask[5], 1);
        do_reset();
        h0 = n_hs;
        idle(5);
        chk("mid_no_commit", n_hs - h0, 0);

        // Randomized traffic.
        for (int k = 0; k < NW; k++) begin
            g_pos[k] = 0;
            g_uuid[k] = {12'($urandom), 32'($urandom)};
            g_tm[k] = NT'($urandom);
        end
        last_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 4) != 0);
                w = $urandom_range(0, NW - 1);
                in_wid = WW'(w);
                in_rd = NR'($urandom);
                in_wb = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0) begin
                    in_is_uop = 0;
                    in_uuid = {12'($urandom), 32'($urandom)};
                    in_tmask = NT'($urandom);
                    in_last = 1'($urandom);
                end else begin
                    in_is_uop = 1;
                    in_uuid = g_uuid[w];
                    if ($urandom_range(0, 49) == 0) in_uuid = in_uuid ^ 44'h1;
                    in_tmask = g_tm[w];
                    if ($urandom_range(0, 49) == 0) in_tmask = in_tmask ^ NT'(1);
                    if (g_pos[w] == UC - 1) in_last = ($urandom_range(0, 99) != 0);
                    else in_last = ($urandom_range(0, 99) == 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
            if (last_acc && in_valid && in_is_uop) begin
                w = int'(in_wid);
                if (in_last) begin
                    g_pos[w] = 0;
                    g_uuid[w] = {12'($urandom), 32'($urandom)};
                    g_tm[w] = NT'($urandom);
                end else begin
                    g_pos[w] = (g_pos[w] + 1) % UC;
                end
            end
        end
        out_ready = 1;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
